// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-requester SRAM arbiter: default geometry
// and requester identifiers.
package sram_arb_pkg;

  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous SRAM (sram_128b_w2048).
// Define SRAM_ARB_RR_EN for round-robin priority; the default build gives requester 0 fixed priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic             gnt0;
  logic             gnt1;
  logic             xfer;
  logic             sel_we;
  logic             both_valid;
  logic             rsp_valid_q;
  logic             rsp_valid_d;
  req_id_t          rsp_id_q;
  req_id_t          rsp_id_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign both_valid = r0_valid & r1_valid;

`ifdef SRAM_ARB_RR_EN
  req_id_t ptr_q;
  req_id_t ptr_d;
`endif

  // Grant uses only valids and the pointer so ready never loops back through we/addr.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (both_valid) begin
`ifdef SRAM_ARB_RR_EN
        if (ptr_q == REQ0) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = r0_valid;
        gnt1 = r1_valid;
      end
    end
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;
  assign xfer     = gnt0 | gnt1;

  always_comb begin
    sel_we   = 1'b0;
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (gnt1) begin
      sel_we   = r1_we;
      sram_cen = 1'b0;
      sram_wen = ~r1_we;
      sram_a   = r1_addr;
      sram_d   = r1_wdata;
    end else if (gnt0) begin
      sel_we   = r0_we;
      sram_cen = 1'b0;
      sram_wen = ~r0_we;
      sram_a   = r0_addr;
      sram_d   = r0_wdata;
    end
  end

  always_comb begin
    rsp_valid_d = xfer & ~sel_we;
    rsp_id_d    = gnt1 ? REQ1 : REQ0;
    cnt_d       = cnt_q;
    if (both_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = gnt0 ? REQ1 : REQ0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ0;
      cnt_q       <= '0;
`ifdef SRAM_ARB_RR_EN
      ptr_q       <= REQ0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      cnt_q       <= cnt_d;
`ifdef SRAM_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // A read issued just before reset must not surface while reset is held.
  assign rsp_valid    = rsp_valid_q & ~reset;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_valid ? sram_q : '0;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter with a behavioural synchronous SRAM beside it and a
// response scoreboard; works with or without SRAM_ARB_RR_EN.
module tb_sram_arbiter;

  localparam int DW = 128;
  localparam int AW = 11;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          r0_valid, r0_ready, r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r1_valid, r1_ready, r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d, sram_q;
  logic          rsp_valid, rsp_id;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  sram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .conflict_cnt(conflict_cnt)
  );

  // Behavioural stand-in for sram_128b_w2048: one-cycle read latency.
  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] = sram_d;
      else sram_q <= mem[sram_a];
    end
  end

  function automatic logic [DW-1:0] pat(int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    int            due;
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic expect_rsp(logic id, logic [DW-1:0] d);
    sb.push_back('{cyc + 1, id, d});
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_data", rsp_data, e.data);
    end else if (rsp_valid) begin
      chk("rsp_unexpected", rsp_valid, 0);
    end
  end

  task automatic drive(logic v0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                       logic v1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1);
    @(posedge clk);
    #1;
    r0_valid = v0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic g;
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    for (int i = 0; i < 2048; i++) mem[i] = pat(i);
    sram_q = '0;
    r0_valid = 1; r0_we = 0; r0_addr = 3; r0_wdata = 0;
    r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;

    // Reset held with a pending request
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_r0_ready", r0_ready, 0);
    chk("reset_cen", sram_cen, 1);
    chk("reset_wen", sram_wen, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_cnt", conflict_cnt, 0);
    @(posedge clk);
    #1 reset = 0; r0_valid = 0;

    for (int k = 0; k < 3; k++) begin
      idle();
      @(negedge clk);
      chk("idle_cen", sram_cen, 1);
      chk("idle_a", sram_a, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
    end

    // Write via r0, read back via r1 next cycle
    drive(1, 1, 5, a5, 0, 0, 0, 0);
    @(negedge clk);
    chk("wr_ready", r0_ready, 1);
    chk("wr_cen", sram_cen, 0);
    chk("wr_wen", sram_wen, 0);
    chk("wr_a", sram_a, 5);
    chk("wr_d", sram_d, a5);
    drive(0, 0, 0, 0, 1, 0, 5, 0);
    expect_rsp(1, a5);
    @(negedge clk);
    chk("rd_ready", r1_ready, 1);
    chk("rd_wen", sram_wen, 1);
    chk("rd_a", sram_a, 5);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, AW'(i), 0, 0, 0, 0, 0);
      expect_rsp(0, pat(i));
      @(negedge clk);
      chk("rdseq_ready", r0_ready, 1);
    end
    idle();
    @(negedge clk);

    // Conflict from a clean pointer
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, AW'(10 + k), 0, 1, 0, AW'(20 + k), 0);
`ifdef SRAM_ARB_RR_EN
      g = k[0];
`else
      g = 1'b0;
`endif
      expect_rsp(g, g ? pat(20 + k) : pat(10 + k));
      @(negedge clk);
      chk("cf_r0_ready", r0_ready, !g);
      chk("cf_r1_ready", r1_ready, g);
      chk("cf_a", sram_a, g ? 20 + k : 10 + k);
    end
    idle();
    @(negedge clk);
    chk("cf_cnt", conflict_cnt, 4);

    // Read accepted, then reset in the response cycle
    drive(1, 0, 2, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_ready", r0_ready, 1);
    @(posedge clk);
    #1 reset = 1; r0_valid = 0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cen", sram_cen, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cnt", conflict_cnt, 0);
    drive(1, 0, 7, 0, 1, 0, 8, 0);
    reset = 0;
    expect_rsp(0, pat(7));
    @(negedge clk);
    chk("ptr_r0_ready", r0_ready, 1);
    chk("ptr_r1_ready", r1_ready, 0);

    // Hold a conflict 2^CW+3 cycles; counter starts at 1 from the cycle above
    for (int k = 0; k < (1 << CW) + 3; k++) begin
      drive(1, 1, 100, 0, 1, 1, 101, 0);
      @(negedge clk);
      if (k == 13) chk("sat_below", conflict_cnt, 14);
      if (k == 14) chk("sat_reach", conflict_cnt, 15);
      if (k == 16) chk("sat_hold", conflict_cnt, 15);
    end
    idle();
    @(negedge clk);
    chk("sat_final", conflict_cnt, 15);
    chk("sat_cen", sram_cen, 1);
    idle();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the SRAM word width in bits.
REQ-002 Parameter ADDR_W, default 11, SHALL set the SRAM address width (2048 words).
REQ-003 Parameter CNT_W, default 16, SHALL set the conflict counter width.
REQ-004 Port clk, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: SHALL be the synchronous, active-high reset.
REQ-006 Ports r0_valid / r1_valid, input, 1: SHALL signal a pending access from requester 0 / 1.
REQ-007 Ports r0_ready / r1_ready, output, 1: SHALL signal that the access is accepted this cycle.
REQ-008 Ports r0_we / r1_we, input, 1: SHALL select the operation, 1 = write and 0 = read.
REQ-009 Ports r0_addr / r1_addr, input, ADDR_W: SHALL carry the word address.
REQ-010 Ports r0_wdata / r1_wdata, input, DATA_W: SHALL carry the write data.
REQ-011 Port sram_cen, output, 1: SHALL drive the active-low chip enable.
REQ-012 Port sram_wen, output, 1: SHALL drive the write enable, 0 = write and 1 = read.
REQ-013 Port sram_a, output, ADDR_W: SHALL drive the SRAM address.
REQ-014 Port sram_d, output, DATA_W: SHALL drive the SRAM write data.
REQ-015 Port sram_q, input, DATA_W: SHALL receive the SRAM read data.
REQ-016 Port rsp_valid, output, 1: SHALL flag read data valid.
REQ-017 Port rsp_id, output, 1: SHALL identify the requester that owns the response.
REQ-018 Port rsp_data, output, DATA_W: SHALL carry the read data.
REQ-019 Port conflict_cnt, output, CNT_W: SHALL count cycles in which both requesters are valid.

Function
REQ-020 The arbiter SHALL grant at most one requester per cycle; a transfer occurs when rX_valid and rX_ready are both 1.
REQ-021 Grant SHALL be decided combinationally from the current valids and the registered priority pointer; a lone valid requester SHALL always be granted.
REQ-022 With a transfer, sram_cen SHALL be 0, sram_wen SHALL equal ~we, and sram_a/sram_d SHALL equal the granted requester's addr/wdata.
REQ-023 With no transfer, sram_cen SHALL be 1, sram_wen SHALL be 1, and sram_a/sram_d SHALL hold 0.
REQ-024 A read accepted in cycle N SHALL produce rsp_valid=1 in cycle N+1, with rsp_id registered and rsp_data = sram_q.
REQ-025 rsp_valid SHALL be 0 after writes and idle cycles; the response path has no backpressure.
REQ-026 Back-to-back reads SHALL sustain one response per cycle.
REQ-027 A write followed by a read to the same address in the next cycle SHALL return the new data.
REQ-028 conflict_cnt SHALL increment when r0_valid and r1_valid are both 1, and SHALL saturate at all-ones.
REQ-029 rX_ready SHALL depend only on valids and the pointer, never on rX_we or rX_addr.

Reset
REQ-030 While reset=1: r0_ready=r1_ready=0, sram_cen=1, sram_wen=1, and no SRAM access occurs.
REQ-031 On reset: rsp_valid=0, rsp_id=0, conflict_cnt=0, and the priority pointer points to requester 0.
REQ-032 A read accepted in the cycle before reset asserts SHALL have its response suppressed if reset is high in the response cycle.

Configuration
REQ-033 With SRAM_ARB_RR_EN defined, priority SHALL be round-robin: after each transfer, the pointer moves to the non-granted requester.
REQ-034 Without SRAM_ARB_RR_EN, requester 0 SHALL have fixed priority and the pointer register SHALL be absent.

Structure
REQ-035 A shared package sram_arb_pkg SHALL hold the DATA_W/ADDR_W defaults and the requester-id constants REQ0=0 and REQ1=1.
REQ-036 The arbiter SHALL contain no SRAM instance and SHALL be instantiated beside sram_128b_w2048.
REQ-037 The arbiter SHALL have no sub-modules; a top-level testbench wrapper SHALL pair it with the SRAM.

Verification
REQ-038 Write 0xA5..A5 via r0 to addr 5, then read addr 5 via r1 -> rsp_valid one cycle later, rsp_id=1, rsp_data=0xA5..A5.
REQ-039 Both requesters read continuously for 4 cycles with RR -> grants 0,1,0,1 and conflict_cnt=4; without RR -> grants 0,0,0,0 and r1_ready=0.
REQ-040 Reads of addr 0,1,2,3 on consecutive cycles -> four consecutive rsp_valid cycles with data in order.
REQ-041 Assert reset in the cycle after a read is accepted -> rsp_valid=0, pointer=0, conflict_cnt=0.
REQ-042 Hold a conflict for 2^CNT_W+3 cycles -> conflict_cnt stays at all-ones.
REQ-043 Idle with no valids -> sram_cen=1 every cycle and rsp_valid=0.
